// File: rtl/song_pkg.sv
`default_nettype none
// ============================================================================
//  Module : song_pkg
//  Shared types and constants for the song sequencer: the ROM note record,
//  reserved note codes, per-note LED patterns and the sequencer state
//  encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package song_pkg;

  // Default record field widths, matching the shipped song library.
  localparam int REC_NOTE_W = 4;
  localparam int REC_OCT_W  = 2;
  localparam int REC_DUR_W  = 4;

  // One ROM word: {note, octave, dur}, note in the most significant bits.
  typedef struct packed {
    logic [REC_NOTE_W-1:0] note;
    logic [REC_OCT_W-1:0]  octave;
    logic [REC_DUR_W-1:0]  dur;
  } note_rec_t;

  // Reserved note codes.
  localparam logic [REC_NOTE_W-1:0] NOTE_REST     = 4'd0;
  localparam logic [REC_NOTE_W-1:0] NOTE_END_CODE = 4'hF;

  // One-hot LED patterns, one lamp per note 1..7.
  localparam logic [6:0] LED_OFF = 7'b0000000;
  localparam logic [6:0] LED_N1  = 7'b0000001;
  localparam logic [6:0] LED_N2  = 7'b0000010;
  localparam logic [6:0] LED_N3  = 7'b0000100;
  localparam logic [6:0] LED_N4  = 7'b0001000;
  localparam logic [6:0] LED_N5  = 7'b0010000;
  localparam logic [6:0] LED_N6  = 7'b0100000;
  localparam logic [6:0] LED_N7  = 7'b1000000;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_END   = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  // LED pattern for a note code; rests and codes above 7 light nothing.
  function automatic logic [6:0] led_for_note(input int unsigned n);
    case (n)
      1:       return LED_N1;
      2:       return LED_N2;
      3:       return LED_N3;
      4:       return LED_N4;
      5:       return LED_N5;
      6:       return LED_N6;
      7:       return LED_N7;
      default: return LED_OFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pulse.sv
`default_nettype none
// ============================================================================
//  Module : edge_pulse
//  Rising-edge detector for a bus of level inputs. Each bit produces a single
//  pulse on its 0->1 transition; a level held high yields only one pulse.
//  Ports  : clk, reset (async, active-low), level_in[WIDTH], rise_out[WIDTH]
//  Revision : 1.0 - initial release
// ============================================================================
module edge_pulse #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level_in,
  output logic [WIDTH-1:0] rise_out
);

  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= level_in;
    end
  end

  // Combinational so the edge is acted on at the same clock that samples it.
  assign rise_out = level_in & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : song_sequencer
//  Auto-play sequencer: walks note records of the selected song in an
//  external synchronous ROM and drives note/octave/LED to the buzzer path.
//  Supports next/prev song select, play/pause, loop-or-advance at song end.
//  Ports  : clk, reset (async, active-low)
//           song_next, song_prev, play_pause (level inputs, rising-edge acted)
//           loop_en, rom_addr -> ROM, rom_data <- ROM ({note, octave, dur})
//           note_out, octave_out, led_out, song_idx, playing, song_done
//  Revision : 1.0 - initial release
// ============================================================================
module song_sequencer
  import song_pkg::*;
#(
  parameter int                CLK_PER_UNIT = 10000000,
  parameter int                NUM_SONGS    = 3,
  parameter int                SONG_LEN     = 56,
  parameter int                NOTE_W       = 4,
  parameter int                OCT_W        = 2,
  parameter int                DUR_W        = 4,
  parameter logic [NOTE_W-1:0] END_CODE     = NOTE_W'(NOTE_END_CODE),
  parameter int                ADDR_W       = $clog2(NUM_SONGS*SONG_LEN)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            song_next,
  input  logic                            song_prev,
  input  logic                            play_pause,
  input  logic                            loop_en,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [NOTE_W+OCT_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]               note_out,
  output logic [OCT_W-1:0]                octave_out,
  output logic [6:0]                      led_out,
  output logic [((NUM_SONGS>1)?$clog2(NUM_SONGS):1)-1:0] song_idx,
  output logic                            playing,
  output logic                            song_done
);

  localparam int SIDX_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int POS_W  = $clog2(SONG_LEN);
  // Duration is counted as units x cycles-per-unit with two small counters,
  // so the longest note never overflows whatever CLK_PER_UNIT is.
  localparam int UNIT_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;

  localparam logic [SIDX_W-1:0] c_last_song = SIDX_W'(NUM_SONGS-1);
  localparam logic [POS_W-1:0]  c_last_pos  = POS_W'(SONG_LEN-1);
  localparam logic [UNIT_W-1:0] c_last_unit = UNIT_W'(CLK_PER_UNIT-1);

  // Edge detection on the user controls: bit 2 next, bit 1 prev, bit 0 play.
  logic [2:0] w_rise;

  edge_pulse #(.WIDTH(3)) u_edges (
    .clk      (clk),
    .reset    (reset),
    .level_in ({song_next, song_prev, play_pause}),
    .rise_out (w_rise)
  );

  logic w_sel_next, w_sel_prev, w_play_edge;
  // Opposing select edges in the same cycle cancel out entirely.
  assign w_sel_next  = w_rise[2] & ~w_rise[1];
  assign w_sel_prev  = w_rise[1] & ~w_rise[2];
  assign w_play_edge = w_rise[0];

  // Registered state.
  state_t              r_state;
  logic [SIDX_W-1:0]   r_song_idx;
  logic [POS_W-1:0]    r_pos;
  logic [UNIT_W-1:0]   r_unit_cnt;
  logic [DUR_W-1:0]    r_dur_cnt;
  logic                r_playing;
  logic [NOTE_W-1:0]   r_note;
  logic [OCT_W-1:0]    r_oct;
  logic [6:0]          r_led;
  logic [NOTE_W-1:0]   r_rec_note;  // last captured record, kept for resume
  logic [OCT_W-1:0]    r_rec_oct;

  // Next-state values.
  state_t              w_state_nxt;
  logic [SIDX_W-1:0]   w_song_nxt;
  logic [POS_W-1:0]    w_pos_nxt;
  logic [UNIT_W-1:0]   w_unit_nxt;
  logic [DUR_W-1:0]    w_dur_nxt;
  logic                w_play_nxt;
  logic [NOTE_W-1:0]   w_note_nxt;
  logic [OCT_W-1:0]    w_oct_nxt;
  logic [6:0]          w_led_nxt;
  logic [NOTE_W-1:0]   w_rec_note_nxt;
  logic [OCT_W-1:0]    w_rec_oct_nxt;

  // ROM record fields.
  logic [NOTE_W-1:0]   w_rom_note;
  logic [OCT_W-1:0]    w_rom_oct;
  logic [DUR_W-1:0]    w_rom_dur;
  logic [DUR_W-1:0]    w_dur_m1;

  assign w_rom_note = rom_data[NOTE_W+OCT_W+DUR_W-1 -: NOTE_W];
  assign w_rom_oct  = rom_data[OCT_W+DUR_W-1 -: OCT_W];
  assign w_rom_dur  = rom_data[DUR_W-1:0];
  // A zero duration plays as one unit.
  assign w_dur_m1   = (w_rom_dur == '0) ? '0 : w_rom_dur - 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_song_nxt     = r_song_idx;
    w_pos_nxt      = r_pos;
    w_unit_nxt     = r_unit_cnt;
    w_dur_nxt      = r_dur_cnt;
    w_note_nxt     = r_note;
    w_oct_nxt      = r_oct;
    w_led_nxt      = r_led;
    w_rec_note_nxt = r_rec_note;
    w_rec_oct_nxt  = r_rec_oct;
    // The select is applied first; the toggle then acts on the new song.
    w_play_nxt     = r_playing ^ w_play_edge;

    if (w_sel_next || w_sel_prev) begin
      // Song select pre-empts every state, including the END auto-advance.
      if (w_sel_next) begin
        w_song_nxt = (r_song_idx == c_last_song) ? '0 : r_song_idx + 1'b1;
      end else begin
        w_song_nxt = (r_song_idx == '0) ? c_last_song : r_song_idx - 1'b1;
      end
      w_pos_nxt   = '0;
      w_unit_nxt  = '0;
      w_dur_nxt   = '0;
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_state_nxt = S_LOAD;
        end
        S_LOAD: begin
          if (w_rom_note == END_CODE) begin
            w_state_nxt = S_END;
          end else begin
            w_rec_note_nxt = w_rom_note;
            w_rec_oct_nxt  = w_rom_oct;
            w_unit_nxt     = '0;
            w_dur_nxt      = w_dur_m1;
            if (w_play_nxt) begin
              w_note_nxt  = w_rom_note;
              w_oct_nxt   = w_rom_oct;
              w_led_nxt   = led_for_note(32'(w_rom_note));
              w_state_nxt = S_HOLD;
            end else begin
              // Paused fetch: the record is kept, outputs stay silent.
              w_state_nxt = S_PAUSE;
            end
          end
        end
        S_HOLD: begin
          if (!w_play_nxt) begin
            w_state_nxt = S_PAUSE;
          end else if (r_unit_cnt == c_last_unit) begin
            w_unit_nxt = '0;
            if (r_dur_cnt == '0) begin
              if (r_pos == c_last_pos) begin
                w_state_nxt = S_END;
              end else begin
                w_pos_nxt   = r_pos + 1'b1;
                w_state_nxt = S_FETCH;
              end
            end else begin
              w_dur_nxt = r_dur_cnt - 1'b1;
            end
          end else begin
            w_unit_nxt = r_unit_cnt + 1'b1;
          end
        end
        S_END: begin
          w_pos_nxt = '0;
          if (!loop_en) begin
            w_song_nxt = (r_song_idx == c_last_song) ? '0 : r_song_idx + 1'b1;
          end
          w_state_nxt = S_FETCH;
        end
        S_PAUSE: begin
          if (w_play_nxt) begin
            w_note_nxt  = r_rec_note;
            w_oct_nxt   = r_rec_oct;
            w_led_nxt   = led_for_note(32'(r_rec_note));
            w_state_nxt = S_HOLD;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end

    // Going to pause silences the buzzer at once; octave is left as is.
    if (w_play_edge && !w_play_nxt) begin
      w_note_nxt = NOTE_W'(NOTE_REST);
      w_led_nxt  = LED_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_song_idx <= '0;
      r_pos      <= '0;
      r_unit_cnt <= '0;
      r_dur_cnt  <= '0;
      r_playing  <= 1'b1;
      r_note     <= '0;
      r_oct      <= '0;
      r_led      <= '0;
      r_rec_note <= '0;
      r_rec_oct  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_song_idx <= w_song_nxt;
      r_pos      <= w_pos_nxt;
      r_unit_cnt <= w_unit_nxt;
      r_dur_cnt  <= w_dur_nxt;
      r_playing  <= w_play_nxt;
      r_note     <= w_note_nxt;
      r_oct      <= w_oct_nxt;
      r_led      <= w_led_nxt;
      r_rec_note <= w_rec_note_nxt;
      r_rec_oct  <= w_rec_oct_nxt;
    end
  end

  assign rom_addr   = ADDR_W'(32'(r_song_idx) * 32'(SONG_LEN) + 32'(r_pos));
  assign note_out   = r_note;
  assign octave_out = r_oct;
  assign led_out    = r_led;
  assign song_idx   = r_song_idx;
  assign playing    = r_playing;
  assign song_done  = (r_state == S_END);

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_song_sequencer
//  Directed self-checking bench for song_sequencer with a behavioural
//  synchronous note ROM (3 songs x 4 slots, 4 clocks per duration unit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_song_sequencer;
  import song_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       song_next = 1'b0;
  logic       song_prev = 1'b0;
  logic       play_pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [3:0] rom_addr;
  logic [9:0] rom_data = '0;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [1:0] song_idx;
  logic       playing;
  logic       song_done;

  int n_cmp = 0;
  int n_bad = 0;

  note_rec_t rom_mem [12];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  song_sequencer #(
    .CLK_PER_UNIT (4),
    .NUM_SONGS    (3),
    .SONG_LEN     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .song_next  (song_next),
    .song_prev  (song_prev),
    .play_pause (play_pause),
    .loop_en    (loop_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_out   (note_out),
    .octave_out (octave_out),
    .led_out    (led_out),
    .song_idx   (song_idx),
    .playing    (playing),
    .song_done  (song_done)
  );

  // One clock: returns on the falling edge, where outputs are sampled and
  // inputs are changed.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out, song_idx, playing, song_done, rom_addr} !==
        {4'd0, 2'd0, 7'd0, 2'd0, 1'b1, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_values: got n=%0d o=%0d led=%b idx=%0d play=%0d done=%0d addr=%0d, want 0 0 0000000 0 1 0 0",
               note_out, octave_out, led_out, song_idx, playing, song_done, rom_addr);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_play();
    int bad;
    cyc();
    n_cmp++;
    if (note_out !== 4'd0) begin
      n_bad++; $display("FAIL latency_early: note got %0d want 0", note_out);
    end
    cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out} !== {4'd1, 2'd1, 7'b0000001}) begin
      n_bad++; $display("FAIL first_note: got n=%0d o=%0d led=%b want 1 1 0000001", note_out, octave_out, led_out);
    end
    // 8 counted cycles plus the 2-cycle gap before the next note.
    bad = 0;
    for (int i = 0; i < 9; i++) begin cyc(); if (note_out !== 4'd1) bad++; end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL note1_hold: %0d samples off, want 0", bad); end
    cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out} !== {4'd3, 2'd0, 7'b0000100}) begin
      n_bad++; $display("FAIL second_note: got n=%0d o=%0d led=%b want 3 0 0000100", note_out, octave_out, led_out);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin cyc(); if (note_out !== 4'd3) bad++; end
    cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out, bad[3:0]} !== {4'd5, 2'd2, 7'b0010000, 4'd0}) begin
      n_bad++; $display("FAIL dur0_note: got n=%0d o=%0d led=%b holdbad=%0d want 5 2 0010000 0", note_out, octave_out, led_out, bad);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin cyc(); if (note_out !== 4'd5) bad++; end
    cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out, bad[3:0]} !== {4'd7, 2'd1, 7'b1000000, 4'd0}) begin
      n_bad++; $display("FAIL last_note: got n=%0d o=%0d led=%b holdbad=%0d want 7 1 1000000 0", note_out, octave_out, led_out, bad);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin cyc(); if (song_done !== 1'b0) bad++; end
    cyc();
    n_cmp++;
    if ({song_done, song_idx, bad[3:0]} !== {1'b1, 2'd0, 4'd0}) begin
      n_bad++; $display("FAIL song_done_pulse: got done=%0d idx=%0d early=%0d want 1 0 0", song_done, song_idx, bad);
    end
    cyc();
    n_cmp++;
    if ({song_done, song_idx, rom_addr} !== {1'b0, 2'd1, 4'd4}) begin
      n_bad++; $display("FAIL advance: got done=%0d idx=%0d addr=%0d want 0 1 4", song_done, song_idx, rom_addr);
    end
    cyc(); cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out} !== {4'd2, 2'd3, 7'b0000010}) begin
      n_bad++; $display("FAIL song1_first: got n=%0d o=%0d led=%b want 2 3 0000010", note_out, octave_out, led_out);
    end
  endtask

  task automatic test_loop_end_code();
    int done_at, done_cnt, end_seen;
    logic [3:0] addr_at7;
    loop_en  = 1'b1;
    done_at  = -1; done_cnt = 0; end_seen = 0; addr_at7 = '0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (song_done === 1'b1) begin done_cnt++; done_at = i; end
      if (note_out === 4'hF) end_seen++;
      if (i == 7) addr_at7 = rom_addr;
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 6) begin
      n_bad++; $display("FAIL endcode_done: got pulses=%0d at=%0d want 1 at 6", done_cnt, done_at);
    end
    n_cmp++;
    if (end_seen != 0) begin n_bad++; $display("FAIL endcode_on_out: got %0d samples want 0", end_seen); end
    n_cmp++;
    if ({addr_at7, song_idx, note_out} !== {4'd4, 2'd1, 4'd2}) begin
      n_bad++; $display("FAIL loop_replay: got addr=%0d idx=%0d n=%0d want 4 1 2", addr_at7, song_idx, note_out);
    end
  endtask

  task automatic test_select_wrap();
    song_next = 1'b1; cyc();
    n_cmp++;
    if ({song_idx, rom_addr} !== {2'd2, 4'd8}) begin
      n_bad++; $display("FAIL next_to2: got idx=%0d addr=%0d want 2 8", song_idx, rom_addr);
    end
    song_next = 1'b0; cyc(); cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out} !== {4'd6, 2'd2, 7'b0100000}) begin
      n_bad++; $display("FAIL song2_first: got n=%0d o=%0d led=%b want 6 2 0100000", note_out, octave_out, led_out);
    end
    song_next = 1'b1; cyc();
    n_cmp++;
    if ({song_idx, rom_addr} !== {2'd0, 4'd0}) begin
      n_bad++; $display("FAIL next_wrap: got idx=%0d addr=%0d want 0 0", song_idx, rom_addr);
    end
    song_next = 1'b0; cyc();
    n_cmp++;
    if (note_out !== 4'd6) begin n_bad++; $display("FAIL wrap_latency_early: got n=%0d want 6", note_out); end
    cyc();
    n_cmp++;
    if (note_out !== 4'd1) begin n_bad++; $display("FAIL wrap_note: got n=%0d want 1", note_out); end
    song_prev = 1'b1; cyc();
    n_cmp++;
    if ({song_idx, rom_addr} !== {2'd2, 4'd8}) begin
      n_bad++; $display("FAIL prev_wrap: got idx=%0d addr=%0d want 2 8", song_idx, rom_addr);
    end
    song_prev = 1'b0; cyc(); cyc();
    n_cmp++;
    if (note_out !== 4'd6) begin n_bad++; $display("FAIL prev_note: got n=%0d want 6", note_out); end
  endtask

  task automatic test_held_and_both();
    int changes;
    logic [1:0] last;
    last = song_idx; changes = 0;
    song_next = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (song_idx !== last) changes++;
      last = song_idx;
    end
    n_cmp++;
    if (changes != 1 || song_idx !== 2'd0) begin
      n_bad++; $display("FAIL held_next: got changes=%0d idx=%0d want 1 0", changes, song_idx);
    end
    song_next = 1'b0; cyc();
    song_next = 1'b1; song_prev = 1'b1; cyc();
    n_cmp++;
    if ({song_idx, rom_addr, note_out} !== {2'd0, 4'd2, 4'd5}) begin
      n_bad++; $display("FAIL both_edges: got idx=%0d addr=%0d n=%0d want 0 2 5", song_idx, rom_addr, note_out);
    end
    song_next = 1'b0; song_prev = 1'b0;
  endtask

  task automatic test_pause_resume();
    bit found;
    int bad;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (note_out === 4'd1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL wait_note1: got timeout want note 1 within 40 cycles"); end
    cyc(); cyc(); cyc();
    play_pause = 1'b1; cyc();
    play_pause = 1'b0;
    n_cmp++;
    if ({note_out, led_out, playing, octave_out} !== {4'd0, 7'd0, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL pause: got n=%0d led=%b play=%0d o=%0d want 0 0000000 0 1", note_out, led_out, playing, octave_out);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if ({note_out, led_out, playing, rom_addr} !== {4'd0, 7'd0, 1'b0, 4'd0}) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL pause_frozen: %0d samples off want 0", bad); end
    play_pause = 1'b1; cyc();
    play_pause = 1'b0;
    n_cmp++;
    if ({note_out, led_out, playing, octave_out} !== {4'd1, 7'b0000001, 1'b1, 2'd1}) begin
      n_bad++; $display("FAIL resume: got n=%0d led=%b play=%0d o=%0d want 1 0000001 1 1", note_out, led_out, playing, octave_out);
    end
    // Five counted cycles remain, then the 2-cycle gap.
    bad = 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (note_out !== 4'd1) bad++; end
    cyc();
    n_cmp++;
    if ({note_out, bad[3:0]} !== {4'd3, 4'd0}) begin
      n_bad++; $display("FAIL resume_remaining: got n=%0d holdbad=%0d want 3 0", note_out, bad);
    end
  endtask

  task automatic test_select_paused();
    play_pause = 1'b1; cyc();
    play_pause = 1'b0;
    song_next  = 1'b1; cyc();
    song_next  = 1'b0;
    n_cmp++;
    if ({song_idx, note_out, playing} !== {2'd1, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL sel_paused: got idx=%0d n=%0d play=%0d want 1 0 0", song_idx, note_out, playing);
    end
    cyc(); cyc();
    n_cmp++;
    if ({note_out, led_out, playing} !== {4'd0, 7'd0, 1'b0}) begin
      n_bad++; $display("FAIL silent_fetch: got n=%0d led=%b play=%0d want 0 0000000 0", note_out, led_out, playing);
    end
    play_pause = 1'b1; cyc();
    play_pause = 1'b0;
    n_cmp++;
    if ({note_out, octave_out, led_out, playing} !== {4'd2, 2'd3, 7'b0000010, 1'b1}) begin
      n_bad++; $display("FAIL play_new_song: got n=%0d o=%0d led=%b play=%0d want 2 3 0000010 1", note_out, octave_out, led_out, playing);
    end
  endtask

  task automatic test_async_reset();
    cyc();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({note_out, octave_out, led_out, song_idx, playing, song_done} !==
        {4'd0, 2'd0, 7'd0, 2'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got n=%0d o=%0d led=%b idx=%0d play=%0d done=%0d want 0 0 0000000 0 1 0",
               note_out, octave_out, led_out, song_idx, playing, song_done);
    end
    cyc();
    reset = 1'b1;
    cyc();
    n_cmp++;
    if (note_out !== 4'd0) begin n_bad++; $display("FAIL post_reset_early: got n=%0d want 0", note_out); end
    cyc();
    n_cmp++;
    if ({note_out, octave_out, led_out} !== {4'd1, 2'd1, 7'b0000001}) begin
      n_bad++; $display("FAIL post_reset_note: got n=%0d o=%0d led=%b want 1 1 0000001", note_out, octave_out, led_out);
    end
  endtask

  initial begin
    rom_mem[0]  = '{note: 4'd1, octave: 2'd1, dur: 4'd2};
    rom_mem[1]  = '{note: 4'd3, octave: 2'd0, dur: 4'd1};
    rom_mem[2]  = '{note: 4'd5, octave: 2'd2, dur: 4'd0};
    rom_mem[3]  = '{note: 4'd7, octave: 2'd1, dur: 4'd1};
    rom_mem[4]  = '{note: 4'd2, octave: 2'd3, dur: 4'd1};
    rom_mem[5]  = '{note: 4'hF, octave: 2'd0, dur: 4'd1};
    rom_mem[6]  = '{note: 4'd4, octave: 2'd0, dur: 4'd1};
    rom_mem[7]  = '{note: 4'd6, octave: 2'd0, dur: 4'd1};
    rom_mem[8]  = '{note: 4'd6, octave: 2'd2, dur: 4'd2};
    rom_mem[9]  = '{note: 4'd4, octave: 2'd1, dur: 4'd1};
    rom_mem[10] = '{note: 4'd2, octave: 2'd0, dur: 4'd1};
    rom_mem[11] = '{note: 4'd1, octave: 2'd3, dur: 4'd1};

    test_reset();
    test_basic_play();
    test_loop_end_code();
    test_select_wrap();
    test_held_and_both();
    test_pause_resume();
    test_select_paused();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
